// File: rtl/knn_pkg.sv
// knn_pkg
// Shared constants and types for the k-NN top-K streaming stage.
//   KNN_N          : keys per sorted input vector
//   KNN_W          : key width in bits (unsigned)
//   dist_t         : one distance key
//   rank_t         : rank / count field wide enough to hold 0..KNN_N
//   stream_state_e : streamer control state
package knn_pkg;

  localparam int KNN_N  = 17;
  localparam int KNN_W  = 32;
  localparam int KNN_KW = $clog2(KNN_N + 1);

  typedef logic [KNN_W-1:0]  dist_t;
  typedef logic [KNN_KW-1:0] rank_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

endpackage : knn_pkg

// File: rtl/knn_topk_streamer_order_check.sv
// knn_order_check
// Purely combinational check that a vector of N keys is non-decreasing.
// Ports:
//   data_i     : N keys packed flat, key i at bits [i*W +: W]
//   unsorted_o : 1 when any key is smaller (unsigned) than its predecessor
module knn_order_check
  import knn_pkg::*;
#(
  parameter int N = KNN_N,
  parameter int W = KNN_W
) (
  input  logic [N*W-1:0] data_i,
  output logic           unsorted_o
);

  // OR-reduce of every adjacent descending pair.
  always_comb begin
    unsorted_o = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (data_i[(i+1)*W +: W] < data_i[i*W +: W]) begin
        unsorted_o = 1'b1;
      end
    end
  end

endmodule : knn_order_check

// File: rtl/knn_topk_streamer.sv
// knn_topk_streamer
// Captures one ascending-sorted vector of N distance keys and streams the
// first k_eff = min(k_cfg, N) keys, smallest first, one per beat over a
// valid/ready interface. Flags vectors that are not non-decreasing.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : vector handshake (in_ready depends on out_ready)
//   in_data             : N keys flat, in_data[0] (bits W-1:0) smallest
//   k_cfg               : number of keys to emit, sampled at capture
//   out_valid/out_ready : beat handshake
//   out_data, out_idx   : key and 0-based rank of the current beat
//   out_last            : current beat is rank k_eff-1
//   order_err           : one-cycle pulse after capturing an unsorted vector
module knn_topk_streamer
  import knn_pkg::*;
#(
  parameter int N  = KNN_N,
  parameter int W  = KNN_W,
  parameter int KW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic [KW-1:0]  k_cfg,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [KW-1:0]  out_idx,
  output logic           out_last,
  output logic           order_err
);

  stream_state_e  state_q;
  logic [W-1:0]   buf_q [N];
  logic [KW-1:0]  keff_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [KW-1:0]  out_idx_q;
  logic           out_last_q;
  logic           order_err_q;

  logic           capture;
  logic           unsorted;
  logic [KW-1:0]  k_eff;
  logic [KW-1:0]  nxt_idx;

  knn_order_check #(
    .N (N),
    .W (W)
  ) u_order_check (
    .data_i     (in_data),
    .unsorted_o (unsorted)
  );

  // A new vector may be taken while idle, or in the very cycle the last beat
  // of the current one is accepted, which gives back-to-back streams without
  // a bubble. This makes in_ready combinational from out_ready.
  assign in_ready = (state_q == IDLE) || (out_valid_q && out_ready && out_last_q);
  assign capture  = in_valid && in_ready;
  assign k_eff    = (k_cfg > KW'(N)) ? KW'(N) : k_cfg;
  assign nxt_idx  = out_idx_q + KW'(1);

  // Key buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= in_data[i*W +: W];
      end
    end
  end

  // Control FSM with registered outputs. The first beat is loaded straight
  // from in_data so it appears the cycle after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      keff_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      order_err_q <= capture && unsorted;
      if (capture) begin
        keff_q    <= k_eff;
        out_idx_q <= '0;
        if (k_eff != '0) begin
          state_q     <= STREAM;
          out_valid_q <= 1'b1;
          out_data_q  <= in_data[W-1:0];
          out_last_q  <= (k_eff == KW'(1));
        end else begin
          // k_cfg of zero: vector is consumed and dropped
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end else if (state_q == STREAM && out_ready) begin
        if (out_last_q) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          out_idx_q   <= '0;
        end else begin
          out_idx_q  <= nxt_idx;
          out_data_q <= buf_q[nxt_idx];
          out_last_q <= (nxt_idx == keff_q - KW'(1));
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign order_err = order_err_q;

endmodule : knn_topk_streamer

// File: tb/tb_knn_topk_streamer.sv
// tb_knn_topk_streamer
// Self-checking bench for knn_topk_streamer. The reference model is a queue
// of pending beats: each capture appends its first min(k,N) keys, each
// accepted beat removes the head.
module tb_knn_topk_streamer;

  localparam int N  = 17;
  localparam int W  = 32;
  localparam int KW = $clog2(N + 1);

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [KW-1:0]  k_cfg;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [KW-1:0]  out_idx;
  logic           out_last;
  logic           order_err;

  logic [W-1:0] curVec [N];
  beat_t        expQ [$];
  bit           expErr;
  int           compared;
  int           mismatched;

  knn_topk_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .k_cfg     (k_cfg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .order_err (order_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports on disagreement.
  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fills curVec with in_data[i] = base + i*step.
  task automatic fillRamp(input int base, input int step);
    for (int i = 0; i < N; i++) curVec[i] = W'(base + i * step);
  endtask

  // One clock cycle: drive inputs at the falling edge, check every output
  // against the model, then advance the model to the next rising edge.
  task automatic applyStimulus(input bit iv, input int k, input bit ordy, output bit captured);
    bit   expReady;
    bit   unsorted;
    int   kEff;
    beat_t b;
    @(negedge clk);
    in_valid  = iv;
    k_cfg     = KW'(k);
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = curVec[i];
    #1;
    checkOutput("out_valid", W'(out_valid), W'(expQ.size() > 0));
    if (expQ.size() > 0) begin
      checkOutput("out_data", out_data, expQ[0].data);
      checkOutput("out_idx", W'(out_idx), W'(expQ[0].idx));
      checkOutput("out_last", W'(out_last), W'(expQ[0].last));
    end
    checkOutput("order_err", W'(order_err), W'(expErr));
    expReady = (expQ.size() == 0) || (ordy && expQ[0].last);
    checkOutput("in_ready", W'(in_ready), W'(expReady));
    if (expQ.size() > 0 && ordy) void'(expQ.pop_front());
    captured = 1'b0;
    expErr   = 1'b0;
    if (iv && expReady) begin
      captured = 1'b1;
      unsorted = 1'b0;
      for (int i = 1; i < N; i++) if (curVec[i] < curVec[i-1]) unsorted = 1'b1;
      expErr = unsorted;
      kEff   = (k > N) ? N : k;
      for (int r = 0; r < kEff; r++) begin
        b.data = curVec[r];
        b.idx  = r;
        b.last = (r == kEff - 1);
        expQ.push_back(b);
      end
    end
    @(posedge clk);
  endtask

  // Presents curVec until captured (bounded), then drains with out_ready=1.
  task automatic runVector(input int k, input int budget);
    bit cap;
    int n;
    cap = 1'b0;
    n   = 0;
    while (!cap && n < budget) begin
      applyStimulus(1'b1, k, 1'b1, cap);
      n++;
    end
    checkOutput("capture_timeout", W'(cap), W'(1));
    n = 0;
    while ((expQ.size() > 0 || expErr) && n < budget) begin
      applyStimulus(1'b0, 0, 1'b1, cap);
      n++;
    end
    applyStimulus(1'b0, 0, 1'b1, cap);
  endtask

  initial begin
    bit cap;
    int n;
    bit rdyPat [7] = '{1, 0, 0, 1, 1, 0, 1};

    compared   = 0;
    mismatched = 0;
    expErr     = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    k_cfg      = '0;
    in_data    = '0;
    fillRamp(0, 10);

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("rst_out_valid", W'(out_valid), W'(0));
    checkOutput("rst_out_idx", W'(out_idx), W'(0));
    checkOutput("rst_out_data", out_data, W'(0));
    checkOutput("rst_out_last", W'(out_last), W'(0));
    checkOutput("rst_order_err", W'(order_err), W'(0));
    checkOutput("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic k=3 stream of a ramp
    fillRamp(0, 10);
    runVector(3, 40);

    // Backpressure with k=4
    applyStimulus(1'b1, 4, 1'b1, cap);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 0, rdyPat[i], cap);
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      applyStimulus(1'b0, 0, 1'b1, cap);
      n++;
    end

    // Back-to-back: A (k=2) then B held on in_valid until taken
    fillRamp(0, 10);
    applyStimulus(1'b1, 2, 1'b1, cap);
    fillRamp(100, 1);
    runVector(2, 20);

    // Boundaries: k=0 dropped, k=20 clamps to 17, k=1 single beat
    fillRamp(5, 3);
    runVector(0, 20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, cap);
    runVector(20, 40);
    runVector(1, 20);

    // Order check: descending pair, all-equal vector, dropped unsorted vector
    fillRamp(0, 10);
    curVec[5] = 7;
    curVec[6] = 3;
    runVector(17, 40);
    fillRamp(42, 0);
    runVector(2, 20);
    fillRamp(0, 10);
    curVec[9] = 1;
    runVector(0, 20);

    // Randomized traffic: mostly sorted vectors, random k, valid and ready
    for (int t = 0; t < 200; t++) begin
      if (!$urandom_range(0, 3) || t == 0) begin
        curVec[0] = W'($urandom_range(0, 1000));
        for (int i = 1; i < N; i++) curVec[i] = curVec[i-1] + W'($urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) curVec[$urandom_range(1, N - 1)] = W'($urandom_range(0, 100));
      end
      applyStimulus($urandom_range(0, 9) < 7, int'($urandom_range(0, 20)), $urandom_range(0, 9) < 7, cap);
    end
    n = 0;
    while ((expQ.size() > 0 || expErr) && n < 60) begin
      applyStimulus(1'b0, 0, 1'b1, cap);
      n++;
    end

    // Asynchronous reset in the middle of a stream at idx 5
    fillRamp(0, 10);
    applyStimulus(1'b1, 17, 1'b1, cap);
    n = 0;
    while (!(expQ.size() > 0 && expQ[0].idx == 5) && n < 30) begin
      applyStimulus(1'b0, 0, 1'b1, cap);
      n++;
    end
    @(negedge clk);
    #1;
    checkOutput("pre_rst_idx", W'(out_idx), W'(5));
    checkOutput("pre_rst_valid", W'(out_valid), W'(1));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", W'(out_valid), W'(0));
    checkOutput("mid_rst_out_idx", W'(out_idx), W'(0));
    checkOutput("mid_rst_out_last", W'(out_last), W'(0));
    checkOutput("mid_rst_in_ready", W'(in_ready), W'(1));
    expQ.delete();
    expErr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fillRamp(200, 2);
    runVector(3, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_knn_topk_streamer
